// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - multiplexed hex driver for a 7-segment display with inter-digit blanking
// Optional macro LEAD_ZERO_BLANK_EN blanks digits above the highest nonzero nibble.
module seg7_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int BLANK_CYCLES   = 16,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_clk,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

  localparam logic [6:0]            SEG_OFF  = ACTIVE_LOW_SEG ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = ACTIVE_LOW_AN ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            CNT_LAST = 8'(BLANK_CYCLES - 1);

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic                    s1_q, s2_q, s3_q;
  logic                    tick;
  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    frame_q, frame_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    load;
  logic [NUM_DIGITS-1:0]   show_mask;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              cur_nib;

  // scan_clk is asynchronous: two sync stages, third flop only for edge detect
  assign tick = s2_q & ~s3_q;

`ifdef LEAD_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] show_mask_q;

  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [4*NUM_DIGITS-1:0] v);
    logic [NUM_DIGITS-1:0] m;
    logic                  seen;
    seen = 1'b0;
    m    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (v[i*4 +: 4] != 4'h0) seen = 1'b1;
      m[i] = seen || (i == 0);
    end
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      show_mask_q <= {NUM_DIGITS{1'b1}};
    end else if (load) begin
      show_mask_q <= lead_zero_mask(value);
    end
  end

  assign show_mask = show_mask_q;
`else
  assign show_mask = {NUM_DIGITS{1'b1}};
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    frame_d  = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      ST_BLANK: begin
        // ticks arriving here are dropped on purpose, not queued
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DRIVE: begin
        if (tick) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            load    = 1'b1;
            frame_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) shadow_d = value;
  end

  always_comb begin
    onehot         = '0;
    onehot[idx_q]  = 1'b1;
    cur_nib        = shadow_q[{idx_q, 2'b00} +: 4];
    an_d           = AN_OFF;
    seg_d          = SEG_OFF;
    if (state_q == ST_DRIVE && digit_en[idx_q] && show_mask[idx_q]) begin
      an_d  = ACTIVE_LOW_AN ? ~onehot : onehot;
      seg_d = ACTIVE_LOW_SEG ? ~hex_decode(cur_nib) : hex_decode(cur_nib);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      frame_q  <= 1'b0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
    end else begin
      s1_q     <= scan_clk;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb/tb_seg7_scan_mux.sv - self-checking bench for seg7_scan_mux against a slot-timing reference model
module tb_seg7_scan_mux;
  localparam int N     = 4;
  localparam int BLANK = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_clk;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NUM_DIGITS    (N),
    .BLANK_CYCLES  (BLANK),
    .ACTIVE_LOW_SEG(1'b1),
    .ACTIVE_LOW_AN (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_clk  (scan_clk),
    .value     (value),
    .digit_en  (digit_en),
    .seg       (seg),
    .an        (an),
    .frame_done(frame_done)
  );

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit auto_sc = 1'b0;
  int sc_half = 60;
  int sc_cnt  = 0;

  // model: scan_clk levels seen at the last three edges, plus slot bookkeeping
  bit          h1, h2, h3;
  bit          m_active = 1'b0;
  int          m_last   = 0;
  int          m_digit  = 0;
  logic [15:0] m_shadow = '0;

  function automatic bit digit_shown(input int d, input logic [15:0] sh);
`ifdef LEAD_ZERO_BLANK_EN
    return (d == 0) || ((sh >> (4 * d)) != 16'h0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic step();
    logic        r, sc, tk;
    logic [15:0] v;
    logic [3:0]  en, exp_an, nib;
    logic [6:0]  exp_seg;
    logic        exp_fd;
    if (auto_sc) begin
      sc_cnt++;
      if (sc_cnt >= sc_half) begin
        sc_cnt   = 0;
        scan_clk = ~scan_clk;
      end
    end
    r  = rst;
    sc = scan_clk;
    v  = value;
    en = digit_en;
    @(posedge clk);
    cyc++;
    exp_an  = 4'hF;
    exp_seg = 7'h7F;
    exp_fd  = 1'b0;
    // a digit is lit from BLANK+1 edges after its accepted tick until the next accepted tick
    if (!r && m_active && (cyc - 1 >= m_last + BLANK) && en[m_digit] && digit_shown(m_digit, m_shadow)) begin
      exp_an[m_digit] = 1'b0;
      nib             = m_shadow[m_digit*4 +: 4];
      exp_seg         = ~hex_tab[nib];
    end
    if (r) begin
      h1 = 0; h2 = 0; h3 = 0;
      m_active = 1'b0;
    end else begin
      tk = h2 & ~h3;
      if (tk && (!m_active || (cyc - 1 >= m_last + BLANK))) begin
        if (!m_active) begin
          m_active = 1'b1;
          m_digit  = 0;
          m_shadow = v;
        end else if (m_digit == N - 1) begin
          m_digit  = 0;
          m_shadow = v;
          exp_fd   = 1'b1;
        end else begin
          m_digit++;
        end
        m_last = cyc;
      end
      h3 = h2; h2 = h1; h1 = sc;
    end
    #1;
    checks++;
    assert (an === exp_an) else begin errors++; $error("FAIL an cyc=%0d got=%h exp=%h", cyc, an, exp_an); end
    checks++;
    assert (seg === exp_seg) else begin errors++; $error("FAIL seg cyc=%0d got=%h exp=%h", cyc, seg, exp_seg); end
    checks++;
    assert (frame_done === exp_fd) else begin errors++; $error("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_fd); end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_an(input logic [3:0] target, input int budget, input string tag);
    int i;
    i = 0;
    while (an !== target && i < budget) begin
      step();
      i++;
    end
    checks++;
    assert (an === target) else begin errors++; $error("FAIL %s wait an got=%h exp=%h", tag, an, target); end
  endtask

  logic [3:0] exp_an_seq  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] exp_seg_seq [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic [3:0] rec_an  [4];
  logic [6:0] rec_seg [4];

  initial begin
    int         nrec, bad, seen2, fd_seen, i, d0;
    logic [3:0] prev_an, a0, exp_next;

    rst = 1'b1; scan_clk = 1'b0; value = 16'h0; digit_en = 4'hF;

    // reset with scan_clk toggling
    for (int k = 0; k < 3; k++) begin
      scan_clk = ~scan_clk;
      step();
      checks++;
      assert (an === 4'hF && seg === 7'h7F && frame_done === 1'b0)
        else begin errors++; $error("FAIL reset_hold an=%h seg=%h fd=%b exp an=F seg=7F fd=0", an, seg, frame_done); end
    end
    rst = 1'b0; scan_clk = 1'b0;
    step();
    checks++;
    assert (an === 4'hF && seg === 7'h7F && frame_done === 1'b0)
      else begin errors++; $error("FAIL reset_release an=%h seg=%h fd=%b exp an=F seg=7F fd=0", an, seg, frame_done); end

    // basic scan of 0x1234
    value = 16'h1234; auto_sc = 1'b1; sc_half = 60; sc_cnt = 0;
    nrec = 0; prev_an = an;
    for (int k = 0; k < 600; k++) begin
      step();
      if (an !== 4'hF && prev_an === 4'hF && nrec < 4) begin
        rec_an[nrec]  = an;
        rec_seg[nrec] = seg;
        nrec++;
      end
      prev_an = an;
    end
    checks++;
    assert (nrec == 4) else begin errors++; $error("FAIL basic_count got=%0d exp=4", nrec); end
    for (int k = 0; k < nrec; k++) begin
      checks++;
      assert (rec_an[k] === exp_an_seq[k] && rec_seg[k] === exp_seg_seq[k])
        else begin errors++; $error("FAIL basic_slot%0d an=%h seg=%h exp an=%h seg=%h", k, rec_an[k], rec_seg[k], exp_an_seq[k], exp_seg_seq[k]); end
    end

    // frame coherency: change value while digit 2 is lit
    wait_an(4'hB, 1000, "coh_d2");
    value = 16'hABCD;
    wait_an(4'h7, 1000, "coh_d3");
    checks++;
    assert (seg === 7'h79) else begin errors++; $error("FAIL coh_old seg got=%h exp=79", seg); end
    i = 0;
    while (frame_done !== 1'b1 && i < 1000) begin step(); i++; end
    checks++;
    assert (frame_done === 1'b1) else begin errors++; $error("FAIL coh_frame_done got=%b exp=1", frame_done); end
    wait_an(4'hE, 1000, "coh_new_d0");
    checks++;
    assert (seg === 7'h21) else begin errors++; $error("FAIL coh_new seg got=%h exp=21", seg); end

    // digit enable 0101
    digit_en = 4'b0101; value = 16'h8888;
    bad = 0; seen2 = 0;
    for (int k = 0; k < 1200; k++) begin
      step();
      if (an === 4'hD || an === 4'h7) bad++;
      if (an === 4'hB) seen2 = 1;
    end
    checks++;
    assert (bad == 0 && seen2 == 1) else begin errors++; $error("FAIL digit_en bad=%0d seen2=%0d exp bad=0 seen2=1", bad, seen2); end

    // extra scan_clk rise during blanking advances the digit only once
    digit_en = 4'hF; auto_sc = 1'b0; scan_clk = 1'b0;
    run(40);
    a0 = an;
    d0 = 0;
    for (int k = 0; k < 4; k++) if (a0[k] == 1'b0) d0 = k;
    exp_next = 4'hF;
    exp_next[(d0 + 1) % 4] = 1'b0;
    scan_clk = 1'b1; run(4);
    scan_clk = 1'b0; run(6);
    scan_clk = 1'b1; run(2);
    scan_clk = 1'b0; run(40);
    checks++;
    assert (an === exp_next) else begin errors++; $error("FAIL ignored_tick an=%h exp=%h", an, exp_next); end

    // reset while digit 3 is driven
    auto_sc = 1'b1; sc_cnt = 0;
    wait_an(4'h7, 2000, "mid_d3");
    rst = 1'b1;
    step();
    checks++;
    assert (an === 4'hF && seg === 7'h7F) else begin errors++; $error("FAIL mid_reset an=%h seg=%h exp F/7F", an, seg); end
    rst = 1'b0;
    i = 0;
    while (an === 4'hF && i < 1000) begin step(); i++; end
    checks++;
    assert (an === 4'hE) else begin errors++; $error("FAIL mid_first_lit an=%h exp=E", an); end

    // randomized phase
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 99) == 0) value = 16'($urandom);
      if ($urandom_range(0, 149) == 0) digit_en = 4'($urandom);
      if ($urandom_range(0, 299) == 0) sc_half = $urandom_range(6, 80);
      if ($urandom_range(0, 199) == 0) scan_clk = ~scan_clk;
      rst = ($urandom_range(0, 1499) == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
